// File: rtl/mem_copy_engine.sv
// Memory-port initiator that copies or fills a block of bytes through a single-port memory.
// Copy takes 2N+1 busy cycles (read/write per word, then DONE); fill takes N+1; start is ignored while busy.
module mem_copy_engine #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  op_fill,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH-1:0] length,
  input  logic [DATA_WIDTH-1:0] fill_value,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_read_en,
  output logic                  mem_write_en,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  fill_op_q, fill_op_d;
  logic [DATA_WIDTH-1:0] fill_val_q, fill_val_d;

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    cnt_d      = cnt_q;
    fill_op_d  = fill_op_q;
    fill_val_d = fill_val_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          src_d      = src_addr;
          dst_d      = dst_addr;
          cnt_d      = length;
          fill_op_d  = op_fill;
          fill_val_d = fill_value;
          if (length == '0)  state_d = DONE;
          else if (op_fill)  state_d = WR;
          else               state_d = RD;
        end
      end
      RD: begin
        src_d   = src_q + ADDR_WIDTH'(1);
        state_d = WR;
      end
      WR: begin
        dst_d = dst_q + ADDR_WIDTH'(1);
        cnt_d = cnt_q - ADDR_WIDTH'(1);
        if (cnt_q == ADDR_WIDTH'(1)) state_d = DONE;
        else if (fill_op_q)          state_d = WR;
        else                         state_d = RD;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      cnt_q      <= '0;
      fill_op_q  <= 1'b0;
      fill_val_q <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      cnt_q      <= cnt_d;
      fill_op_q  <= fill_op_d;
      fill_val_q <= fill_val_d;
    end
  end

  // Everything below depends only on registered state, so reset clears the
  // enables without waiting for a clock edge.
  always_comb begin
    busy           = (state_q != IDLE);
    done           = (state_q == DONE);
    mem_address    = '0;
    mem_write_data = '0;
    mem_read_en    = 1'b0;
    mem_write_en   = 1'b0;
    case (state_q)
      RD: begin
        mem_read_en = 1'b1;
        mem_address = src_q;
      end
      WR: begin
        mem_write_en   = 1'b1;
        mem_address    = dst_q;
        mem_write_data = fill_op_q ? fill_val_q : mem_read_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: behavioural memory, expected-access scoreboard and directed copy/fill cases.
module tb_mem_copy_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       op_fill = 1'b0;
  logic [7:0] src_addr = 8'h00;
  logic [7:0] dst_addr = 8'h00;
  logic [7:0] length = 8'h00;
  logic [7:0] fill_value = 8'h00;
  logic       busy, done;
  logic [7:0] mem_address, mem_write_data, mem_read_data;
  logic       mem_read_en, mem_write_en;

  mem_copy_engine #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op_fill(op_fill),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .fill_value(fill_value), .busy(busy), .done(done),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Single-port memory with registered read data.
  logic [7:0] mem [0:255];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[0] = 8'hA1;
    mem[1] = 8'hB2;
    mem[2] = 8'hC3;
    mem_read_data = 8'h00;
    forever begin
      @(posedge clk);
      if (mem_write_en) mem[mem_address] <= mem_write_data;
      if (mem_read_en)  mem_read_data    <= mem[mem_address];
    end
  end

  typedef struct packed {
    logic [1:0] kind;   // 0 read, 1 write, 2 done
    logic [7:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t sb_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input logic [1:0] kind, input logic [7:0] addr, input logic [7:0] data);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    sb_q.push_back(e);
  endtask

  // Monitor: every enable or done cycle must match the next expected event.
  always @(negedge clk) begin
    if (!rst) begin
      check("en_exclusive", {31'd0, mem_read_en & mem_write_en}, 32'd0);
      if (!busy || done)
        check("idle_quiet", {14'd0, mem_read_en, mem_write_en, mem_address, mem_write_data}, 32'd0);
      if (mem_read_en || mem_write_en || done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_event", {29'd0, done, mem_write_en, mem_read_en}, 32'd0);
        end else begin
          ev_t e;
          logic [1:0] k;
          e = sb_q.pop_front();
          k = done ? 2'd2 : (mem_write_en ? 2'd1 : 2'd0);
          check("event_kind", {30'd0, k}, {30'd0, e.kind});
          if (e.kind != 2'd2) check("event_addr", {24'd0, mem_address}, {24'd0, e.addr});
          if (e.kind == 2'd1) check("write_data", {24'd0, mem_write_data}, {24'd0, e.data});
        end
      end
    end
  end

  // Issues one request and measures how long busy stays high.
  task automatic run_op(input logic fill, input logic [7:0] src, input logic [7:0] dst,
                        input logic [7:0] len, input logic [7:0] fv, input int exp_busy,
                        input bit inject_start);
    int busy_cnt;
    int cyc;
    bit seen_done;
    @(posedge clk); #1;
    start = 1'b1; op_fill = fill; src_addr = src; dst_addr = dst;
    length = len; fill_value = fv;
    @(posedge clk); #1;
    start = 1'b0; src_addr = 8'h00; dst_addr = 8'h00; length = 8'h00; fill_value = 8'h00;
    busy_cnt = 0;
    seen_done = 1'b0;
    for (cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (inject_start && cyc == 2) begin
        start = 1'b1; op_fill = 1'b0; src_addr = 8'h80; dst_addr = 8'h90; length = 8'd5;
      end else if (inject_start && cyc == 3) begin
        start = 1'b0; src_addr = 8'h00; dst_addr = 8'h00; length = 8'h00;
      end
      if (done) begin
        seen_done = 1'b1;
        break;
      end
    end
    if (!seen_done) check("done_timeout", 32'd0, 32'd1);
    check("busy_cycles", busy_cnt, exp_busy);
    @(negedge clk);
    check("busy_after_done", {31'd0, busy}, 32'd0);
    check("sb_drained", sb_q.size(), 32'd0);
  endtask

  initial begin
    #2;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_enables", {30'd0, mem_read_en, mem_write_en}, 32'd0);
    check("rst_addr_data", {16'd0, mem_address, mem_write_data}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Copy 3 words 0x00 -> 0x10.
    push_ev(0, 8'h00, 8'h00); push_ev(1, 8'h10, 8'hA1);
    push_ev(0, 8'h01, 8'h00); push_ev(1, 8'h11, 8'hB2);
    push_ev(0, 8'h02, 8'h00); push_ev(1, 8'h12, 8'hC3);
    push_ev(2, 8'h00, 8'h00);
    run_op(1'b0, 8'h00, 8'h10, 8'd3, 8'h00, 7, 1'b0);
    check("copy_mem10", {24'd0, mem[8'h10]}, 32'hA1);
    check("copy_mem11", {24'd0, mem[8'h11]}, 32'hB2);
    check("copy_mem12", {24'd0, mem[8'h12]}, 32'hC3);

    // Fill 4 words of 0x5A at 0x20.
    for (int i = 0; i < 4; i++) push_ev(1, 8'h20 + 8'(i), 8'h5A);
    push_ev(2, 8'h00, 8'h00);
    run_op(1'b1, 8'h77, 8'h20, 8'd4, 8'h5A, 5, 1'b0);
    for (int i = 0; i < 4; i++) check("fill_mem", {24'd0, mem[8'h20 + 8'(i)]}, 32'h5A);
    check("fill_mem24_untouched", {24'd0, mem[8'h24]}, 32'h24);

    // Zero length: DONE only.
    push_ev(2, 8'h00, 8'h00);
    run_op(1'b0, 8'h00, 8'h30, 8'd0, 8'h00, 1, 1'b0);
    check("zero_len_mem30", {24'd0, mem[8'h30]}, 32'h30);

    // Source wraps FE, FF, 00; a start mid-transfer is ignored.
    push_ev(0, 8'hFE, 8'h00); push_ev(1, 8'h40, 8'hFE);
    push_ev(0, 8'hFF, 8'h00); push_ev(1, 8'h41, 8'hFF);
    push_ev(0, 8'h00, 8'h00); push_ev(1, 8'h42, 8'hA1);
    push_ev(2, 8'h00, 8'h00);
    run_op(1'b0, 8'hFE, 8'h40, 8'd3, 8'h00, 7, 1'b1);
    check("wrap_mem42", {24'd0, mem[8'h42]}, 32'hA1);
    check("ignored_mem90", {24'd0, mem[8'h90]}, 32'h90);
    repeat (3) @(negedge clk);
    check("ignored_stays_idle", {31'd0, busy}, 32'd0);

    // Fill 10 words, reset after the third write commits.
    for (int i = 0; i < 3; i++) push_ev(1, 8'h60 + 8'(i), 8'h33);
    @(posedge clk); #1;
    start = 1'b1; op_fill = 1'b1; dst_addr = 8'h60; length = 8'd10; fill_value = 8'h33;
    @(posedge clk); #1;
    start = 1'b0; dst_addr = 8'h00; length = 8'h00; fill_value = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_enables", {30'd0, mem_read_en, mem_write_en}, 32'd0);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_mid_sb", sb_q.size(), 32'd0);
    for (int i = 0; i < 3; i++) check("rst_mid_written", {24'd0, mem[8'h60 + 8'(i)]}, 32'h33);
    check("rst_mid_mem63", {24'd0, mem[8'h63]}, 32'h63);

    // Fresh copy after reset.
    push_ev(0, 8'h10, 8'h00); push_ev(1, 8'h70, 8'hA1);
    push_ev(0, 8'h11, 8'h00); push_ev(1, 8'h71, 8'hB2);
    push_ev(2, 8'h00, 8'h00);
    run_op(1'b0, 8'h10, 8'h70, 8'd2, 8'h00, 5, 1'b0);
    check("post_rst_mem70", {24'd0, mem[8'h70]}, 32'hA1);
    check("post_rst_mem71", {24'd0, mem[8'h71]}, 32'hB2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Memory-port initiator: drives the single-port byte memory interface (address, write data, read enable, write enable, registered read data) to copy or fill a block of bytes without CPU involvement.
- Sits between the control/datapath start logic and the data memory, in place of the datapath's own memory requests while busy.
- Memory contract:
  - Read data is registered: it is valid the cycle after read enable is sampled.
  - Read enable has priority inside the memory, so this block never asserts both enables.

Parameters:
ADDR_WIDTH, 8, width of memory address and length/count.
DATA_WIDTH, 8, width of a memory word.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  one-cycle request; accepted only in IDLE.
op_fill  input  1  sampled with start: 0 = copy, 1 = fill.
src_addr  input  ADDR_WIDTH  copy source base; ignored for fill.
dst_addr  input  ADDR_WIDTH  destination base.
length  input  ADDR_WIDTH  number of words to transfer (0..255).
fill_value  input  DATA_WIDTH  word written in fill mode, sampled with start.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse at end of operation.
mem_address  output  ADDR_WIDTH  memory address.
mem_write_data  output  DATA_WIDTH  memory write data.
mem_read_en  output  1  memory read request.
mem_write_en  output  1  memory write request.
mem_read_data  input  DATA_WIDTH  memory registered read data.

Behaviour:
- Reset (async, immediate):
  - State IDLE; busy=0, done=0, mem_read_en=0, mem_write_en=0, mem_address=0, mem_write_data=0.
  - Internal src/dst pointers, remaining count, op and fill registers cleared.
- States and transitions:
  - IDLE → on start=1 at an edge, latch src_addr, dst_addr, length, op_fill, fill_value.
    - length==0: → DONE.
    - op_fill=1: → WR.
    - Otherwise: → RD.
  - RD: mem_read_en=1, mem_address=src_ptr, mem_write_en=0. Next edge: src_ptr+1, → WR.
  - WR: mem_write_en=1, mem_address=dst_ptr, mem_read_en=0.
    - mem_write_data = mem_read_data (copy) or latched fill value (fill).
    - Next edge: dst_ptr+1, count-1.
    - If count was 1 → DONE; else → RD (copy) or stay in WR (fill).
  - DONE: done=1, both enables 0. Next edge → IDLE unconditionally.
- Outputs are decoded from the registered state and pointers; no input-to-output combinational path except mem_read_data → mem_write_data in copy WR.
- In IDLE and DONE: mem_address=0, mem_write_data=0.
- Timing:
  - Copy of N≥1 words: busy for 2N+1 cycles.
  - Fill of N≥1 words: busy for N+1 cycles.
  - length 0: busy for 1 cycle (DONE only), no memory access.
  - done asserts in the cycle after the last write.
- Addressing:
  - Pointers wrap modulo 2^ADDR_WIDTH (0xFF+1=0x00), no error.
  - Copy is strictly ascending. Overlapping regions are copied forward word by word: each word is read just before it is written.
- Invariants:
  - mem_read_en and mem_write_en are never both 1.
  - No enable is asserted in IDLE or DONE.
- start while busy (including DONE) is ignored; inputs sampled only at acceptance.
- Reset mid-operation:
  - Enables drop immediately; no done pulse.
  - Partially written memory is left as is.
  - The next start after reset release behaves as from power-up.

Test Plan:
- Copy: mem[0x00..0x02]={0xA1,0xB2,0xC3}, start copy src=0x00 dst=0x10 len=3.
  - Enable sequence R,W,R,W,R,W on addresses 00,10,01,11,02,12.
  - done 7 cycles after acceptance.
  - mem[0x10..0x12]={0xA1,0xB2,0xC3}.
- Fill: dst=0x20 len=4 fill_value=0x5A.
  - mem_write_en high 4 consecutive cycles, addresses 0x20–0x23.
  - done next cycle; those locations read back 0x5A.
- Zero length: start len=0 → busy 1 cycle, done pulse, no read/write enable ever asserted.
- Wrap and ignore: copy src=0xFE dst=0x40 len=3 → reads FE, FF, 00.
  - A second start pulsed mid-transfer with len=5 has no effect.
  - Exactly one done pulse.
- Reset mid-op: fill len=10, assert rst after 3rd write.
  - Enables and busy go 0 without waiting for a clock; no done.
  - Only 3 words modified; a fresh copy afterwards completes correctly.
- Protocol monitor on all tests: read and write enables never high together; copy write data equals previously read value.
